// File: rtl/seq_array_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Optional signed mode via macro SIGNED_MODE_EN (adds port sgn).
module seq_array_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     addend;
  logic              last_bit;
`ifdef SIGNED_MODE_EN
  logic              sgn_q, sgn_d;
`endif

  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign p         = (state_q == StDone) ? acc_q : '0;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`ifdef SIGNED_MODE_EN
    sgn_d    = sgn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d  = StCalc;
          cnt_d    = '0;
          acc_d    = '0;
          mplier_d = b;
`ifdef SIGNED_MODE_EN
          mcand_d  = {{WIDTH{sgn & a[WIDTH-1]}}, a};
          sgn_d    = sgn;
`else
          mcand_d  = {{WIDTH{1'b0}}, a};
`endif
        end
      end
      StCalc: begin
`ifdef SIGNED_MODE_EN
        // The multiplier MSB carries negative weight in two's complement.
        if (sgn_q && last_bit) acc_d = acc_q - addend;
        else                   acc_d = acc_q + addend;
`else
        acc_d = acc_q + addend;
`endif
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef SIGNED_MODE_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`ifdef SIGNED_MODE_EN
      sgn_q    <= sgn_d;
`endif
    end
  end

endmodule

// File: doc/seq_array_mult.md
SEQ_ARRAY_MULT -- requirements
Module: seq_array_mult

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port in_valid  input  1  operands a/b (and sgn) valid.
REQ-005 SHALL provide port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL provide port a  input  WIDTH  multiplicand.
REQ-007 SHALL provide port b  input  WIDTH  multiplier.
REQ-008 SHALL provide port sgn  input  1  signed-mode select, present only with SIGNED_MODE_EN (REQ-031).
REQ-009 SHALL provide port out_valid  output  1  product valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts product.
REQ-011 SHALL provide port p  output  2*WIDTH  product.
REQ-012 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-014 in_ready SHALL equal 1 in IDLE only; 0 in CALC and DONE.
REQ-015 Accept = in_valid and in_ready at a rising edge; on accept, a, b and sgn SHALL be registered and FSM SHALL enter CALC with bit counter cleared.
REQ-016 in_valid while in_ready=0 SHALL be ignored; operands SHALL NOT be sampled.
REQ-017 CALC SHALL process one multiplier bit per cycle, LSB first: add a (shifted to the current bit position) to the accumulator when the bit is 1, then advance.
REQ-018 CALC SHALL last exactly WIDTH cycles for every operand value; no early termination on zero or small operands.
REQ-019 out_valid SHALL rise on the edge WIDTH cycles after the accept edge; FSM SHALL enter DONE at that edge.
REQ-020 In DONE, p SHALL hold the full 2*WIDTH product, stable, until handshake.
REQ-021 out_valid and out_ready high at an edge SHALL complete the handshake; FSM SHALL return to IDLE and out_valid SHALL drop at that edge.
REQ-022 No new operand SHALL be accepted on the handshake edge; earliest next accept is the following edge (one op per WIDTH+2 cycles minimum).
REQ-023 Unsigned result: p = a*b exactly; no overflow is possible in 2*WIDTH bits.
REQ-024 Signed result (sgn=1): p = two's-complement a*b modulo 2^(2*WIDTH); most-negative times most-negative SHALL produce its exact positive value.
REQ-025 p SHALL read 0 outside DONE.
REQ-026 out_ready held high before DONE SHALL have no effect.

Reset
REQ-027 When rst is high at a rising edge, FSM SHALL go to IDLE, accumulator, counter and operand registers SHALL clear, regardless of state.
REQ-028 Reset values: in_ready=1, out_valid=0, busy=0, p=0.
REQ-029 Reset during CALC or DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-030 in_valid high in the same cycle as rst SHALL NOT be accepted.

Configuration
REQ-031 Macro SIGNED_MODE_EN defined: port sgn exists and REQ-024 applies when sgn=1; sgn=0 gives unsigned.
REQ-032 Macro SIGNED_MODE_EN undefined: port sgn absent, all operands unsigned, no signed-correction logic synthesised.

Verification
REQ-033 WIDTH=4, unsigned: a=15, b=15 -> out_valid exactly 4 cycles after accept, p=0xE1 (225).
REQ-034 WIDTH=8, unsigned: a=0xFF, b=0xFF -> p=0xFE01; a=0, b=0xA5 -> p=0x0000, same 8-cycle latency.
REQ-035 WIDTH=4, SIGNED_MODE_EN, sgn=1: a=-8, b=-8 -> p=0x40; a=-1, b=7 -> p=0xF9; sgn=0 with a=0xF, b=0x7 -> p=0x69.
REQ-036 WIDTH=8: 3*5 completes, out_ready held low 5 cycles -> p=0x000F and out_valid stable throughout; in_valid pulses meanwhile ignored (in_ready=0).
REQ-037 WIDTH=8: assert rst 2 cycles into CALC -> next cycle in_ready=1, out_valid=0, p=0; no product emitted; next op 2*3 -> p=6.
REQ-038 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly WIDTH+2 cycles, products in order.
